// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises configuration words LSB-first into a ccff
// chain, then recirculates the chain once and compares a CRC-16 of the bits
// sent against a CRC-16 of the bits that come back out of the tail.
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic              prog_clock,
    input  logic              prog_resetb,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BL_W   = $clog2(WORD_W + 1);
    localparam int RM_W   = $clog2(CHAIN_LEN + 1);
    localparam int WL_W   = $clog2(NWORDS + 1);

    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
    localparam logic [BL_W-1:0] BL_FULL = BL_W'(WORD_W);
    localparam logic [RM_W-1:0] RM_ONE  = RM_W'(1);
    localparam logic [RM_W-1:0] RM_LEN  = RM_W'(CHAIN_LEN);
    localparam logic [WL_W-1:0] WL_ONE  = WL_W'(1);
    localparam logic [WL_W-1:0] WL_ALL  = WL_W'(NWORDS);
    localparam logic [15:0]     CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One step of a bit-serial CRC-16, polynomial 0x1021.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    state_t            state_r, state_n;
    logic [WORD_W-1:0] sh_r, sh_n;
    logic [BL_W-1:0]   bits_left_r, bits_left_n;
    logic [RM_W-1:0]   remaining_r, remaining_n;   // load bits, then verify shifts
    logic [WL_W-1:0]   words_left_r, words_left_n;
    logic [15:0]       crc_tx_r, crc_tx_n;
    logic [15:0]       crc_rx_r, crc_rx_n;
    logic              error_r, error_n;

    logic              ready_s;
    logic              shift_s;
    logic [RM_W-1:0]   rem_after_s;
    logic [15:0]       crc_rx_step_s;

    // Output decode: everything here depends only on registered state
    // (ccff_tail is looped straight back to the head while verifying).
    always_comb begin
        ready_s       = 1'b0;
        cfg_ready     = 1'b0;
        ccff_head     = 1'b0;
        config_enable = 1'b0;
        busy          = (state_r != ST_IDLE);
        done          = (state_r == ST_DONE);
        error         = error_r;
        case (state_r)
            ST_LOAD: begin
                ready_s       = (words_left_r != '0) && (bits_left_r <= BL_ONE);
                cfg_ready     = ready_s;
                ccff_head     = sh_r[0];
                config_enable = (bits_left_r != '0);
            end
            ST_VERIFY: begin
                ccff_head     = ccff_tail;
                config_enable = 1'b1;
            end
            default: begin
                ccff_head     = 1'b0;
            end
        endcase
    end

    // Next-state and datapath update for the load/verify sequencer.
    always_comb begin
        state_n       = state_r;
        sh_n          = sh_r;
        bits_left_n   = bits_left_r;
        remaining_n   = remaining_r;
        words_left_n  = words_left_r;
        crc_tx_n      = crc_tx_r;
        crc_rx_n      = crc_rx_r;
        error_n       = error_r;
        shift_s       = (bits_left_r != '0);
        rem_after_s   = shift_s ? (remaining_r - RM_ONE) : remaining_r;
        crc_rx_step_s = crc16_step(crc_rx_r, ccff_tail);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n      = ST_LOAD;
                    sh_n         = '0;
                    bits_left_n  = '0;
                    remaining_n  = RM_LEN;
                    words_left_n = WL_ALL;
                    crc_tx_n     = CRC_INIT;
                    crc_rx_n     = CRC_INIT;
                    error_n      = 1'b0;
                end else begin
                    state_n      = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_n     = ST_IDLE;
                    bits_left_n = '0;
                    error_n     = 1'b1;
                end else begin
                    if (shift_s) begin
                        sh_n        = sh_r >> 1;
                        bits_left_n = bits_left_r - BL_ONE;
                        remaining_n = rem_after_s;
                        crc_tx_n    = crc16_step(crc_tx_r, sh_r[0]);
                    end else begin
                        remaining_n = remaining_r;
                    end
                    if (ready_s && cfg_valid) begin
                        // Last word may be partial: only the bits the chain still needs.
                        sh_n         = cfg_data;
                        words_left_n = words_left_r - WL_ONE;
                        if (32'(rem_after_s) >= 32'(WORD_W)) begin
                            bits_left_n = BL_FULL;
                        end else begin
                            bits_left_n = BL_W'(rem_after_s);
                        end
                    end else begin
                        words_left_n = words_left_r;
                    end
                    if (rem_after_s == '0) begin
                        state_n     = ST_VERIFY;
                        bits_left_n = '0;
                        remaining_n = RM_LEN;
                    end else begin
                        state_n     = ST_LOAD;
                    end
                end
            end
            ST_VERIFY: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    error_n = 1'b1;
                end else begin
                    crc_rx_n    = crc_rx_step_s;
                    remaining_n = remaining_r - RM_ONE;
                    if (remaining_r == RM_ONE) begin
                        state_n = ST_DONE;
                        error_n = (crc_rx_step_s != crc_tx_r);
                    end else begin
                        state_n = ST_VERIFY;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge prog_clock or negedge prog_resetb) begin
        if (!prog_resetb) begin
            state_r      <= ST_IDLE;
            sh_r         <= '0;
            bits_left_r  <= '0;
            remaining_r  <= '0;
            words_left_r <= '0;
            crc_tx_r     <= 16'h0000;
            crc_rx_r     <= 16'h0000;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_n;
            sh_r         <= sh_n;
            bits_left_r  <= bits_left_n;
            remaining_r  <= remaining_n;
            words_left_r <= words_left_n;
            crc_tx_r     <= crc_tx_n;
            crc_rx_r     <= crc_rx_n;
            error_r      <= error_n;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Table-driven bench for ccff_chain_loader with a 20-bit chain model.
module tb_ccff_chain_loader;

    localparam int W = 8;
    localparam int N = 20;

    logic         prog_clock = 1'b0;
    logic         prog_resetb;
    logic         start;
    logic         abort;
    logic [W-1:0] cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         ccff_head;
    logic         ccff_tail;
    logic         config_enable;
    logic         busy;
    logic         done;
    logic         error;

    int errors = 0;
    int checks = 0;

    // Chain model: head enters at bit N-1, tail is bit 0; stuck bits forced to 1.
    logic [N-1:0] chain_q = '0;
    logic [N-1:0] stuck_mask = '0;
    logic [N-1:0] chain_eff;
    assign chain_eff = chain_q | stuck_mask;
    assign ccff_tail = chain_eff[0];

    always @(posedge prog_clock) begin
        if (config_enable) chain_q <= {ccff_head, chain_eff[N-1:1]};
    end

    always #5 prog_clock = ~prog_clock;

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(N)) dut (
        .prog_clock    (prog_clock),
        .prog_resetb   (prog_resetb),
        .start         (start),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .config_enable (config_enable),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    typedef struct {
        logic [7:0]   w0, w1, w2;
        int           stall;
        logic [N-1:0] stuck;
        bit           mid_start;
        bit           idle_valid;
        int           exp_done;
        int           exp_en;
        bit           chk_chain;
        logic [N-1:0] exp_chain;
        logic         exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 0);
        check({tag, "_ccff_head"}, ccff_head, 0);
        check({tag, "_config_enable"}, config_enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // mode 0: full load; mode 1: abort in cycle 'cut'; mode 2: reset in cycle 'cut'
    task automatic run_load(input vec_t v, input int mode, input int cut);
        logic [7:0] words [3];
        int  widx, stall_left, en_cnt;
        bit  finished;
        words[0] = v.w0; words[1] = v.w1; words[2] = v.w2;
        stuck_mask = v.stuck;
        widx = 0; stall_left = v.stall; en_cnt = 0; finished = 1'b0;
        if (v.idle_valid) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge prog_clock);
                cfg_valid = 1'b1;
                cfg_data  = v.w0;
                #1;
                check("idle_cfg_ready", cfg_ready, 0);
            end
        end
        @(negedge prog_clock);
        start = 1'b1;
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            @(negedge prog_clock);
            start = (v.mid_start && cyc == 5);
            abort = 1'b0;
            if (cyc == 1) begin
                check("start_busy", busy, 1);
                check("start_cfg_ready", cfg_ready, 1);
                check("start_error_cleared", error, 0);
                check("start_config_enable", config_enable, 0);
            end
            if (mode == 2 && cyc == cut) begin
                #2 prog_resetb = 1'b0;
                #1 check_reset_outputs("midreset");
                @(negedge prog_clock);
                prog_resetb = 1'b1;
                finished = 1'b1;
            end else if (mode == 1 && cyc == cut + 1) begin
                check("abort_config_enable", config_enable, 0);
                check("abort_busy", busy, 0);
                check("abort_error", error, 1);
                check("abort_done", done, 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge prog_clock);
                    check("abort_no_done", done, 0);
                end
                finished = 1'b1;
            end else if (done) begin
                check("done_cycle", cyc, v.exp_done);
                check("enable_cycles", en_cnt, v.exp_en);
                check("error_at_done", error, v.exp_err);
                if (v.chk_chain) check("chain_content", chain_q, v.exp_chain);
                @(negedge prog_clock);
                check("done_single_pulse", done, 0);
                check("idle_after_done", busy, 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge prog_clock);
                    check("error_held", error, v.exp_err);
                end
                finished = 1'b1;
            end else begin
                if (mode == 1 && cyc == cut) begin
                    check("abort_on_shift_en", config_enable, 1);
                    check("abort_shift_count", en_cnt, 9);
                    abort = 1'b1;
                end
                if (config_enable) en_cnt++;
                if (widx == 1 && cfg_ready && stall_left > 0) begin
                    cfg_valid = 1'b0;
                    stall_left--;
                end else if (widx < 3) begin
                    cfg_valid = 1'b1;
                    cfg_data  = words[widx];
                end else begin
                    cfg_valid = 1'b0;
                end
                if (cfg_valid && cfg_ready) widx++;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within 200 cycles, got none expected cycle %0d", v.exp_done);
        end
        start = 1'b0;
        abort = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        //        w0     w1     w2    stall stuck      mid  idle done en  chk  chain       err
        tbl[0] = '{8'hA5, 8'h3C, 8'hF9, 0, 20'h00000, 1'b0, 1'b0, 42, 40, 1'b1, 20'h93CA5, 1'b0};
        tbl[1] = '{8'hA5, 8'h3C, 8'hF9, 5, 20'h00000, 1'b0, 1'b0, 47, 40, 1'b1, 20'h93CA5, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 8'h00, 0, 20'h00080, 1'b0, 1'b0, 42, 40, 1'b0, 20'h00000, 1'b1};
        tbl[3] = '{8'hA5, 8'h3C, 8'hF9, 0, 20'h00000, 1'b1, 1'b0, 42, 40, 1'b1, 20'h93CA5, 1'b0};
        tbl[4] = '{8'hFF, 8'h00, 8'h5A, 0, 20'h00000, 1'b0, 1'b1, 42, 40, 1'b1, 20'hA00FF, 1'b0};
        tbl[5] = '{8'h12, 8'h34, 8'h56, 3, 20'h00000, 1'b0, 1'b0, 45, 40, 1'b1, 20'h63412, 1'b0};

        prog_resetb = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        #2 check_reset_outputs("reset");
        #10 prog_resetb = 1'b1;

        for (int i = 0; i < 6; i++) run_load(tbl[i], 0, 0);

        // abort during the 10th LOAD shift (shift cycles run 2..21 unstalled)
        run_load(tbl[0], 1, 11);
        // asynchronous reset in the middle of VERIFY (cycles 22..41), then a clean load
        run_load(tbl[0], 2, 30);
        run_load(tbl[0], 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
